// File: rtl/lcd_pixel_gen.sv
// Test-pattern source for an RGB565 LCD serializer: valid/ready pixel stream
// with start/end-of-line/frame flags, a completed-frame counter and an optional inter-frame gap.
module lcd_pixel_gen #(
  parameter int H_ACTIVE   = 240,
  parameter int V_ACTIVE   = 135,
  parameter int GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic [1:0]  pattern,
  input  logic [15:0] solid_color,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] pix_data,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_eof,
  output logic [15:0] frame_count,
  output logic        busy
);

  // x and y are at least 4 bits wide so bit 3 always exists for the checkerboard.
  localparam int XW      = ($clog2(H_ACTIVE) < 4) ? 4 : $clog2(H_ACTIVE);
  localparam int YW      = ($clog2(V_ACTIVE) < 4) ? 4 : $clog2(V_ACTIVE);
  localparam int TOTAL   = H_ACTIVE * V_ACTIVE;
  localparam int LW      = $clog2(TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
  localparam logic [LW-1:0] LIN_LAST = LW'(TOTAL - 1);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
  localparam logic [15:0]   GAP_LAST = 16'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t state, next_state;

  logic [XW-1:0] x, nx;
  logic [YW-1:0] y, ny;
  logic [LW-1:0] lin, nlin;
  logic [2:0]    bar_idx, nbar_idx;
  logic [BW-1:0] bar_cnt, nbar_cnt;
  logic [LW-1:0] dot, dot_next;
  logic [15:0]   gap_cnt;
  logic [1:0]    pat_q, sel_pat;
  logic [15:0]   color_q, sel_color;
  logic [15:0]   next_pixel;
  logic          next_sof, next_eol, next_eof;

  logic xfer;
  logic start_frame;
  logic advance;
  logic finish;

  function automatic logic [15:0] pixel_value(
    input logic [1:0]    pat,
    input logic [15:0]   color,
    input logic [XW-1:0] px,
    input logic [YW-1:0] py,
    input logic [2:0]    bar,
    input logic [LW-1:0] lin_pos,
    input logic [LW-1:0] dot_pos
  );
    logic [15:0] val;
    val = 16'h0000;
    case (pat)
      2'd0: val = color;
      2'd1: begin
        case (bar)
          3'd0:    val = 16'hFFFF;
          3'd1:    val = 16'hFFE0;
          3'd2:    val = 16'h07FF;
          3'd3:    val = 16'h07E0;
          3'd4:    val = 16'hF81F;
          3'd5:    val = 16'hF800;
          3'd6:    val = 16'h001F;
          default: val = 16'h0000;
        endcase
      end
      2'd2:    val = (px[3] ^ py[3]) ? 16'h0000 : 16'hFFFF;
      default: val = (lin_pos == dot_pos) ? 16'hFFFF : 16'h0000;
    endcase
    return val;
  endfunction

  assign xfer = pix_valid & pix_ready;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A frame may start from IDLE, at the end of the gap, or straight off the eof transfer.
  always_comb begin
    next_state  = state;
    start_frame = 1'b0;
    advance     = 1'b0;
    finish      = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          start_frame = 1'b1;
          next_state  = ACTIVE;
        end
      end
      ACTIVE: begin
        if (xfer) begin
          if (pix_eof) begin
            finish = 1'b1;
            if (GAP_CYCLES != 0) begin
              next_state = GAP;
            end else if (enable) begin
              start_frame = 1'b1;
            end else begin
              next_state = IDLE;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (enable) begin
            start_frame = 1'b1;
            next_state  = ACTIVE;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Coordinates of the pixel that will be presented after this edge.
  always_comb begin
    nx       = x;
    ny       = y;
    nlin     = lin;
    nbar_idx = bar_idx;
    nbar_cnt = bar_cnt;
    if (start_frame) begin
      nx       = '0;
      ny       = '0;
      nlin     = '0;
      nbar_idx = '0;
      nbar_cnt = '0;
    end else if (advance) begin
      nlin = lin + 1'b1;
      if (x == X_LAST) begin
        nx       = '0;
        ny       = y + 1'b1;
        nbar_idx = '0;
        nbar_cnt = '0;
      end else begin
        nx = x + 1'b1;
        if (bar_cnt == BAR_LAST) begin
          nbar_cnt = '0;
          nbar_idx = bar_idx + 1'b1;
        end else begin
          nbar_cnt = bar_cnt + 1'b1;
        end
      end
    end
  end

  // The first pixel of a back-to-back frame must already see the advanced dot.
  always_comb begin
    dot_next = dot;
    if (finish) begin
      dot_next = (dot == LIN_LAST) ? '0 : dot + 1'b1;
    end
    sel_pat    = start_frame ? pattern : pat_q;
    sel_color  = start_frame ? solid_color : color_q;
    next_pixel = pixel_value(sel_pat, sel_color, nx, ny, nbar_idx, nlin, dot_next);
    next_sof   = (nx == '0) && (ny == '0);
    next_eol   = (nx == X_LAST);
    next_eof   = (nx == X_LAST) && (ny == Y_LAST);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x           <= '0;
      y           <= '0;
      lin         <= '0;
      bar_idx     <= '0;
      bar_cnt     <= '0;
      dot         <= '0;
      gap_cnt     <= '0;
      pat_q       <= '0;
      color_q     <= '0;
      frame_count <= '0;
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_sof     <= 1'b0;
      pix_eol     <= 1'b0;
      pix_eof     <= 1'b0;
    end else begin
      x       <= nx;
      y       <= ny;
      lin     <= nlin;
      bar_idx <= nbar_idx;
      bar_cnt <= nbar_cnt;
      dot     <= dot_next;
      if (finish) begin
        frame_count <= frame_count + 16'd1;
      end
      if (state == GAP && gap_cnt != GAP_LAST) begin
        gap_cnt <= gap_cnt + 16'd1;
      end else begin
        gap_cnt <= '0;
      end
      if (start_frame) begin
        pat_q   <= pattern;
        color_q <= solid_color;
      end
      if (start_frame || advance) begin
        pix_valid <= 1'b1;
        pix_data  <= next_pixel;
        pix_sof   <= next_sof;
        pix_eol   <= next_eol;
        pix_eof   <= next_eof;
      end else if (finish) begin
        pix_valid <= 1'b0;
        pix_sof   <= 1'b0;
        pix_eol   <= 1'b0;
        pix_eof   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lcd_pixel_gen.sv
// Self-checking bench for lcd_pixel_gen: a full-size instance plus two 8x2
// instances (back-to-back and 3-cycle gap) checked against a pixel-rule model.
module tb_lcd_pixel_gen;

  localparam int MH = 240;
  localparam int MV = 135;
  localparam int SH = 8;
  localparam int SV = 2;

  logic clk = 1'b0;
  logic resetn;

  logic        enable;
  logic [1:0]  pattern;
  logic [15:0] solid_color;
  logic        pix_ready;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_sof, pix_eol, pix_eof;
  logic [15:0] frame_count;
  logic        busy;

  logic        s_en   [2];
  logic [1:0]  s_pat  [2];
  logic [15:0] s_col  [2];
  logic        s_rdy  [2];
  logic        s_pv   [2];
  logic [15:0] s_pd   [2];
  logic        s_sof  [2];
  logic        s_eol  [2];
  logic        s_eof  [2];
  logic [15:0] s_fc   [2];
  logic        s_busy [2];

  int vectors = 0;
  int miscompares = 0;
  int mx, my, mdot;
  int sdot [2];
  int s_total [2];
  int main_sof, main_eol, main_eof, main_done;
  logic [15:0] cap [0:MV-1][0:MH-1];

  typedef struct {
    logic [1:0]  pat;
    int          x;
    int          y;
    logic [15:0] exp;
  } spot_t;
  spot_t spots [9];

  lcd_pixel_gen dut_main (
    .clk(clk), .resetn(resetn), .enable(enable), .pattern(pattern),
    .solid_color(solid_color), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
    .frame_count(frame_count), .busy(busy)
  );

  lcd_pixel_gen #(.H_ACTIVE(SH), .V_ACTIVE(SV), .GAP_CYCLES(0)) dut_b2b (
    .clk(clk), .resetn(resetn), .enable(s_en[0]), .pattern(s_pat[0]),
    .solid_color(s_col[0]), .pix_valid(s_pv[0]), .pix_ready(s_rdy[0]),
    .pix_data(s_pd[0]), .pix_sof(s_sof[0]), .pix_eol(s_eol[0]), .pix_eof(s_eof[0]),
    .frame_count(s_fc[0]), .busy(s_busy[0])
  );

  lcd_pixel_gen #(.H_ACTIVE(SH), .V_ACTIVE(SV), .GAP_CYCLES(3)) dut_gap (
    .clk(clk), .resetn(resetn), .enable(s_en[1]), .pattern(s_pat[1]),
    .solid_color(s_col[1]), .pix_valid(s_pv[1]), .pix_ready(s_rdy[1]),
    .pix_data(s_pd[1]), .pix_sof(s_sof[1]), .pix_eol(s_eol[1]), .pix_eof(s_eof[1]),
    .frame_count(s_fc[1]), .busy(s_busy[1])
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Pixel colour straight from the pattern rules: division for bars, product for the dot.
  function automatic logic [15:0] model_pixel(input logic [1:0] pat, input logic [15:0] col,
                                              input int x, input int y, input int h, input int dot);
    logic [15:0] val;
    val = 16'h0000;
    case (pat)
      2'd0: val = col;
      2'd1: begin
        case (x / (h / 8))
          0:       val = 16'hFFFF;
          1:       val = 16'hFFE0;
          2:       val = 16'h07FF;
          3:       val = 16'h07E0;
          4:       val = 16'hF81F;
          5:       val = 16'hF800;
          6:       val = 16'h001F;
          default: val = 16'h0000;
        endcase
      end
      2'd2:    val = ((((x / 8) % 2) + ((y / 8) % 2)) == 1) ? 16'h0000 : 16'hFFFF;
      default: val = ((y * h + x) == dot) ? 16'hFFFF : 16'h0000;
    endcase
    return val;
  endfunction

  task automatic model_step(inout int x, inout int y, inout int dot, input int h, input int v,
                            output bit frame_end);
    frame_end = 1'b0;
    if (x == h - 1) begin
      x = 0;
      if (y == v - 1) begin
        y = 0;
        dot = (dot + 1) % (h * v);
        frame_end = 1'b1;
      end else begin
        y = y + 1;
      end
    end else begin
      x = x + 1;
    end
  endtask

  task automatic checkResetState();
    checkOutput("rst_main_outputs", 32'({pix_valid, pix_sof, pix_eol, pix_eof, busy, pix_data}), 32'd0);
    checkOutput("rst_main_frame_count", 32'(frame_count), 32'd0);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("rst_small%0d_outputs", k),
                  32'({s_pv[k], s_sof[k], s_eol[k], s_eof[k], s_busy[k], s_pd[k]}), 32'd0);
      checkOutput($sformatf("rst_small%0d_frame_count", k), 32'(s_fc[k]), 32'd0);
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    resetn = 1'b0;
    #1;
    checkResetState();
    repeat (2) @(negedge clk);
    checkResetState();
    resetn = 1'b1;
    mx = 0;
    my = 0;
    mdot = 0;
    for (int k = 0; k < 2; k++) begin
      sdot[k] = 0;
      s_total[k] = 0;
    end
  endtask

  task automatic run_main(input logic [1:0] pat, input logic [15:0] col, input int nxfer,
                          input int ready_pct, input bit single_frame);
    int cycles;
    logic stalled;
    logic [18:0] held;
    logic [15:0] exp_pd;
    logic [2:0] exp_fl;
    bit fe;
    cycles = 0;
    stalled = 1'b0;
    held = '0;
    main_done = 0;
    main_sof = 0;
    main_eol = 0;
    main_eof = 0;
    pattern = pat;
    solid_color = col;
    enable = 1'b1;
    while (main_done < nxfer && cycles < nxfer * 4 + 1000) begin
      @(negedge clk);
      cycles++;
      if (stalled) begin
        checkOutput("main_stall_hold", 32'({pix_data, pix_sof, pix_eol, pix_eof}), 32'(held));
      end
      pix_ready = (int'($urandom_range(99, 0)) < ready_pct);
      if (pix_valid && pix_ready) begin
        exp_pd = model_pixel(pat, col, mx, my, MH, mdot);
        exp_fl = {(mx == 0 && my == 0), (mx == MH - 1), (mx == MH - 1 && my == MV - 1)};
        checkOutput("main_pix_data", 32'(pix_data), 32'(exp_pd));
        checkOutput("main_flags", 32'({pix_sof, pix_eol, pix_eof}), 32'(exp_fl));
        main_sof += int'(pix_sof);
        main_eol += int'(pix_eol);
        main_eof += int'(pix_eof);
        cap[my][mx] = pix_data;
        model_step(mx, my, mdot, MH, MV, fe);
        main_done++;
        if (main_done == 1) begin
          pattern = 2'($urandom);
          solid_color = 16'($urandom);
          if (single_frame) enable = 1'b0;
        end
      end
      stalled = pix_valid && !pix_ready;
      held = {pix_data, pix_sof, pix_eol, pix_eof};
    end
    if (main_done < nxfer) checkOutput("main_timeout", 32'(main_done), 32'(nxfer));
  endtask

  task automatic applyStimulus(input logic [1:0] pat, input logic [15:0] col, input int nxfer,
                               input int ready_pct, input bit single_frame);
    applyReset();
    run_main(pat, col, nxfer, ready_pct, single_frame);
  endtask

  task automatic run_small(input int k, input logic [1:0] pat, input logic [15:0] col,
                           input int nframes, input int ready_pct, input int exp_gap);
    int cycles, frames, x, y, d, idle_run, ff_pos, ff_cnt;
    bit after_eof, fe;
    logic stalled;
    logic [18:0] held;
    logic [15:0] exp_pd;
    logic [2:0] exp_fl;
    cycles = 0;
    frames = 0;
    x = 0;
    y = 0;
    idle_run = 0;
    ff_pos = -1;
    ff_cnt = 0;
    after_eof = 1'b0;
    stalled = 1'b0;
    held = '0;
    s_pat[k] = pat;
    s_col[k] = col;
    s_en[k] = 1'b1;
    while (frames < nframes && cycles < 5000) begin
      @(negedge clk);
      cycles++;
      if (stalled) begin
        checkOutput("small_stall_hold", 32'({s_pd[k], s_sof[k], s_eol[k], s_eof[k]}), 32'(held));
      end
      if (after_eof) begin
        if (s_pv[k]) begin
          checkOutput($sformatf("small%0d_gap_len", k), 32'(idle_run), 32'(exp_gap));
          after_eof = 1'b0;
        end else begin
          idle_run++;
        end
      end
      if (frames == nframes - 1 && s_pv[k]) s_en[k] = 1'b0;
      s_rdy[k] = (int'($urandom_range(99, 0)) < ready_pct);
      if (s_pv[k] && s_rdy[k]) begin
        exp_pd = model_pixel(pat, col, x, y, SH, sdot[k]);
        exp_fl = {(x == 0 && y == 0), (x == SH - 1), (x == SH - 1 && y == SV - 1)};
        checkOutput($sformatf("small%0d_pix_data", k), 32'(s_pd[k]), 32'(exp_pd));
        checkOutput($sformatf("small%0d_flags", k), 32'({s_sof[k], s_eol[k], s_eof[k]}), 32'(exp_fl));
        if (s_pd[k] == 16'hFFFF) begin
          ff_cnt++;
          ff_pos = y * SH + x;
        end
        d = sdot[k];
        model_step(x, y, d, SH, SV, fe);
        sdot[k] = d;
        if (fe) begin
          if (pat == 2'd3) begin
            checkOutput($sformatf("small%0d_dot_count f%0d", k, s_total[k]), 32'(ff_cnt), 32'd1);
            checkOutput($sformatf("small%0d_dot_pos f%0d", k, s_total[k]), 32'(ff_pos),
                        32'(s_total[k] % (SH * SV)));
          end
          frames++;
          s_total[k]++;
          after_eof = 1'b1;
          idle_run = 0;
          ff_cnt = 0;
          ff_pos = -1;
        end
      end
      stalled = s_pv[k] && !s_rdy[k];
      held = {s_pd[k], s_sof[k], s_eol[k], s_eof[k]};
    end
    if (frames < nframes) checkOutput($sformatf("small%0d_timeout", k), 32'(frames), 32'(nframes));
  endtask

  initial begin
    int gap_busy;
    resetn = 1'b0;
    enable = 1'b0;
    pattern = 2'd0;
    solid_color = 16'h0000;
    pix_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_en[k] = 1'b0;
      s_pat[k] = 2'd0;
      s_col[k] = 16'h0000;
      s_rdy[k] = 1'b0;
    end

    spots[0] = '{2'd1, 29, 0, 16'hFFFF};
    spots[1] = '{2'd1, 30, 0, 16'hFFE0};
    spots[2] = '{2'd1, 119, 0, 16'h07E0};
    spots[3] = '{2'd1, 209, 0, 16'h001F};
    spots[4] = '{2'd1, 210, 0, 16'h0000};
    spots[5] = '{2'd1, 239, 0, 16'h0000};
    spots[6] = '{2'd2, 7, 0, 16'hFFFF};
    spots[7] = '{2'd2, 8, 0, 16'h0000};
    spots[8] = '{2'd2, 8, 8, 16'hFFFF};

    $display("[TB] reset and full default frame, solid F800");
    applyStimulus(2'd0, 16'hF800, MH * MV, 100, 1'b1);
    checkOutput("frame_sof_count", 32'(main_sof), 32'd1);
    checkOutput("frame_eol_count", 32'(main_eol), 32'(MV));
    checkOutput("frame_eof_count", 32'(main_eof), 32'd1);
    @(negedge clk);
    checkOutput("frame_count_after_frame", 32'(frame_count), 32'd1);
    checkOutput("idle_after_frame", 32'({pix_valid, busy}), 32'd0);
    pix_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("ready_while_idle", 32'({pix_valid, busy, frame_count}), 32'({2'b00, 16'd1}));
    end

    $display("[TB] colour bars and checkerboard spot table");
    for (int p = 1; p <= 2; p++) begin
      applyStimulus(2'(p), 16'h0000, (p == 1) ? MH : 9 * MH + 16, (p == 1) ? 100 : 50, 1'b0);
      for (int i = 0; i < 9; i++) begin
        if (int'(spots[i].pat) == p) begin
          checkOutput($sformatf("spot p%0d x%0d y%0d", p, spots[i].x, spots[i].y),
                      32'(cap[spots[i].y][spots[i].x]), 32'(spots[i].exp));
        end
      end
    end

    $display("[TB] reset at pixel 100 while stalled");
    applyStimulus(2'd0, 16'h1234, 100, 100, 1'b0);
    @(negedge clk);
    pix_ready = 1'b0;
    @(negedge clk);
    checkOutput("stalled_before_reset", 32'(pix_valid), 32'd1);
    applyReset();
    run_main(2'd0, 16'h07E0, 20, 100, 1'b0);
    checkOutput("post_reset_sof_count", 32'(main_sof), 32'd1);

    $display("[TB] 8x2 moving dot, back-to-back frames");
    enable = 1'b0;
    applyReset();
    run_small(0, 2'd3, 16'h0000, 17, 60, 0);
    @(negedge clk);
    checkOutput("b2b_frame_count", 32'(s_fc[0]), 32'd17);
    checkOutput("b2b_idle", 32'({s_pv[0], s_busy[0]}), 32'd0);

    $display("[TB] 8x2 with 3-cycle gap, enable dropped in last frame");
    run_small(1, 2'd3, 16'h0000, 3, 70, 3);
    gap_busy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s_busy[1] && !s_pv[1]) gap_busy++;
      else break;
    end
    checkOutput("gap_busy_cycles", 32'(gap_busy), 32'd3);
    checkOutput("gap_then_idle", 32'({s_pv[1], s_busy[1]}), 32'd0);
    checkOutput("gap_frame_count", 32'(s_fc[1]), 32'd3);
    s_rdy[1] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("gap_idle_ready", 32'({s_pv[1], s_busy[1], s_fc[1]}), 32'({2'b00, 16'd3}));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
